bmp_arbiter_rr: RTL and testbench
=================================

Name: bmp_arbiter_rr

Overview:
- Parametrised N-channel successor to the two-slave BMP arbiter.
- Grants one slave channel at a time, round-robin, and locks the grant for a whole packet (until the slave's last word).
- Streams granted words to the image processor with a valid/ready handshake and buffers processor results in an internal output FIFO.
- Drains that FIFO to master port 0, tagging each word with its source channel and flagging packet completion.

Parameters:
- N_CH, 2, number of slave channels (2..8).
- DATA_BUS_SIZE, 32, data word width in bits.
- FIFO_DEPTH, 16, output FIFO depth in words (power of two, >=4).
- CH_W, $clog2(N_CH), channel-index width (derived, do not override).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- slv_mode  in  2*N_CH  per-channel mode; channel i at [2i+1:2i].
- slv_data_valid  in  N_CH  per-channel word valid.
- slv_data  in  N_CH*DATA_BUS_SIZE  per-channel data word.
- slv_last  in  N_CH  marks the final word of a packet.
- slv_data_proc  in  8*N_CH  per-channel processing argument.
- slv_ready  out  N_CH  per-channel accept; at most one bit high.
- data_to_processor  out  DATA_BUS_SIZE  word to the processor.
- scheduler_2_proc_vld  out  1  data_to_processor is valid.
- proc_rdy  in  1  processor accepts a word.
- mode  out  2  latched mode of the granted channel.
- data_proc  out  8  latched processing argument of the granted channel.
- done  out  1  one-cycle pulse when the last input word is accepted by the processor.
- data_from_processor  in  DATA_BUS_SIZE  result word.
- vld_pr  in  1  result word valid; there is no backpressure toward the processor.
- mstr0_ready  in  1  master accepts a word.
- data_to_master  out  DATA_BUS_SIZE  FIFO head word.
- mstr0_data_valid  out  1  data_to_master is valid (FIFO not empty).
- mstr0_chan  out  CH_W  source channel of the head word.
- mstr0_cmplt  out  1  high together with the final word of a packet.

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM state is IDLE.
  - Round-robin pointer is 0.
  - FIFO is empty; in-flight counter is 0.
- FSM state IDLE:
  - If any slv_data_valid is high, go to XFER on the next cycle.
  - The grant goes to the first requesting channel at or after the pointer, wrapping modulo N_CH.
  - On grant, latch mode, data_proc and the channel index; the pointer becomes grant+1 mod N_CH.
- FSM state XFER:
  - slv_ready[g] = proc_rdy && credit_ok; all other slv_ready bits are 0.
  - The processor side is combinational pass-through: data_to_processor = slv_data[g], scheduler_2_proc_vld = slv_data_valid[g] && credit_ok.
  - A word transfers when slv_data_valid[g] && slv_ready[g].
  - Each transfer increments the in-flight counter.
  - A transfer with slv_last[g] high pulses done for one cycle and moves the FSM to DRAIN.
- FSM state DRAIN:
  - Stay until the in-flight counter is 0, i.e. every result of the packet has been written to the FIFO.
  - Then return to IDLE, giving a one-cycle bubble before the next grant.
- Credit rule:
  - credit_ok = (fifo_count + inflight) < FIFO_DEPTH.
  - This guarantees that vld_pr never meets a full FIFO.
  - A vld_pr arriving while inflight == 0 is a protocol error: assert in simulation and drop the word.
- Result path:
  - vld_pr writes {channel, last_flag, data} into the FIFO and decrements inflight.
  - last_flag is set when the in-flight counter goes from 1 to 0 while in DRAIN.
  - Simultaneous increment and decrement leave inflight unchanged.
- Master side:
  - mstr0_data_valid = !empty; data_to_master, mstr0_chan and mstr0_cmplt come from the head entry.
  - A pop happens when valid && mstr0_ready.
  - Simultaneous push and pop in the same cycle are both allowed, including when the FIFO is full.
  - Read latency 0 (first-word fall-through).
- Grant stability: the grant, mode and data_proc stay constant from grant until the FSM returns to IDLE; slave valid changes mid-packet do not affect them.
- Reset mid-packet:
  - Abandons the packet immediately and flushes the FIFO.
  - Zeroes the counters; the next cycle is IDLE.
- Counter widths: inflight and fifo_count are $clog2(FIFO_DEPTH)+1 bits and never wrap.

Decomposition:
- Package bmp_arb_pkg holds:
  - the state encoding (IDLE, XFER, DRAIN);
  - the mode encodings;
  - the FIFO entry layout: the CH_W+1+DATA_BUS_SIZE packing order.
- One sub-module, bmp_out_fifo: a parametrised synchronous FWFT FIFO with count, full and empty outputs.
- The round-robin pick stays inline as a function.

Test Plan:
- Single packet:
  - Stimulus: channel 0, 3 words 0x11, 0x22, 0x33 (last on 0x33); processor echoes with 2-cycle latency; mstr0_ready=1.
  - Required: done pulses on the 0x33 accept; master receives 0x11, 0x22, 0x33 with chan=0 and mstr0_cmplt only on 0x33.
- Round-robin fairness:
  - Stimulus: N_CH=4, channels 1 and 3 continuously requesting 1-word packets.
  - Required: grant sequence 1, 3, 1, 3; channel 0 never asserts slv_ready.
- Backpressure:
  - Stimulus: FIFO_DEPTH=4, mstr0_ready=0, 10-word packet.
  - Required: slv_ready drops after 4 accepted words; no vld_pr overflow; after mstr0_ready=1 all 10 words arrive in order.
- Processor stall:
  - Stimulus: proc_rdy=0 for 5 cycles mid-packet.
  - Required: slv_ready low for those cycles; no duplicated or lost words.
- Reset mid-XFER:
  - Stimulus: assert rst after 2 of 5 words.
  - Required: next cycle all outputs are 0 and the FIFO is empty; a following packet from channel 1 completes normally.
- Simultaneous push and pop:
  - Stimulus: full FIFO with vld_pr and mstr0_ready both high.
  - Required: count stays at FIFO_DEPTH and the data order is preserved.

Source files
------------

// File: rtl/bmp_arb_pkg.sv
// Shared definitions for the round-robin BMP arbiter: FSM encoding, slave mode
// codes and the output FIFO entry layout.
package bmp_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_XFER  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_INVERT = 2'd1,
        MODE_THRESH = 2'd2,
        MODE_SCALE  = 2'd3
    } bmp_mode_e;

    // FIFO entry packing, MSB first: {chan[ch_w-1:0], last, data[dw-1:0]}
    function automatic int fifo_entry_w(input int ch_w, input int dw);
        return ch_w + 1 + dw;
    endfunction

endpackage

// File: rtl/bmp_out_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Push into a full FIFO is accepted only when a pop happens in the same cycle.
module bmp_out_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Storage is not reset, so the head is masked while empty.
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/bmp_arbiter_rr.sv
// N-channel round-robin packet arbiter feeding the image processor; results are
// buffered in a credit-protected FIFO and drained to master port 0.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | no grant; pick next requester at or after the RR pointer
//   XFER     | stream granted slave words to the processor until last
//   DRAIN    | wait for all in-flight results of the packet to reach FIFO
module bmp_arbiter_rr
    import bmp_arb_pkg::*;
#(
    parameter int N_CH          = 2,
    parameter int DATA_BUS_SIZE = 32,
    parameter int FIFO_DEPTH    = 16,
    localparam int CH_W         = $clog2(N_CH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [2*N_CH-1:0]             slv_mode,
    input  logic [N_CH-1:0]               slv_data_valid,
    input  logic [N_CH*DATA_BUS_SIZE-1:0] slv_data,
    input  logic [N_CH-1:0]               slv_last,
    input  logic [8*N_CH-1:0]             slv_data_proc,
    output logic [N_CH-1:0]               slv_ready,
    output logic [DATA_BUS_SIZE-1:0]      data_to_processor,
    output logic                          scheduler_2_proc_vld,
    input  logic                          proc_rdy,
    output logic [1:0]                    mode,
    output logic [7:0]                    data_proc,
    output logic                          done,
    input  logic [DATA_BUS_SIZE-1:0]      data_from_processor,
    input  logic                          vld_pr,
    input  logic                          mstr0_ready,
    output logic [DATA_BUS_SIZE-1:0]      data_to_master,
    output logic                          mstr0_data_valid,
    output logic [CH_W-1:0]               mstr0_chan,
    output logic                          mstr0_cmplt
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = fifo_entry_w(CH_W, DATA_BUS_SIZE);

    function automatic logic [CH_W-1:0] rr_pick(input logic [N_CH-1:0] req,
                                                input logic [CH_W-1:0] ptr);
        logic [CH_W-1:0] pick;
        logic            found;
        int              idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            idx = (int'(ptr) + k) % N_CH;
            if (!found && req[idx]) begin
                pick  = CH_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [CH_W-1:0] rr_next(input logic [CH_W-1:0] g);
        return (g == CH_W'(N_CH - 1)) ? '0 : g + 1'b1;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [CH_W-1:0]    ptr_q, ptr_d;
    logic [CH_W-1:0]    grant_q, grant_d;
    logic [1:0]         mode_q, mode_d;
    logic [7:0]         data_proc_q, data_proc_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;

    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_din, fifo_dout;
    logic               fifo_pop;
    logic [CNT_W:0]     credit_sum;
    logic               credit_ok;
    logic               xfer_fire, res_push, res_last;
    logic               g_valid, g_last;
    logic [DATA_BUS_SIZE-1:0] g_data;

    assign g_valid    = slv_data_valid[grant_q];
    assign g_last     = slv_last[grant_q];
    assign g_data     = slv_data[int'(grant_q)*DATA_BUS_SIZE +: DATA_BUS_SIZE];
    // Counting in-flight words reserves FIFO space before the result exists.
    assign credit_sum = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign credit_ok  = credit_sum < (CNT_W+1)'(FIFO_DEPTH);

    always_comb begin
        slv_ready            = '0;
        data_to_processor    = '0;
        scheduler_2_proc_vld = 1'b0;
        xfer_fire            = 1'b0;
        done                 = 1'b0;
        if (state_q == ST_XFER) begin
            slv_ready[grant_q]   = proc_rdy && credit_ok;
            data_to_processor    = g_data;
            scheduler_2_proc_vld = g_valid && credit_ok;
            xfer_fire            = g_valid && proc_rdy && credit_ok;
            done                 = xfer_fire && g_last;
        end
    end

    assign res_push   = vld_pr && (inflight_q != '0);
    assign res_last   = res_push && (state_q == ST_DRAIN) && (inflight_q == CNT_W'(1));
    assign inflight_d = inflight_q + CNT_W'(xfer_fire) - CNT_W'(res_push);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        mode_d      = mode_q;
        data_proc_d = data_proc_q;
        case (state_q)
            ST_IDLE: begin
                if (|slv_data_valid) begin
                    grant_d     = rr_pick(slv_data_valid, ptr_q);
                    ptr_d       = rr_next(grant_d);
                    mode_d      = slv_mode[int'(grant_d)*2 +: 2];
                    data_proc_d = slv_data_proc[int'(grant_d)*8 +: 8];
                    state_d     = ST_XFER;
                end
            end
            ST_XFER: begin
                if (done) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (inflight_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            mode_q      <= '0;
            data_proc_q <= '0;
            inflight_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            mode_q      <= mode_d;
            data_proc_q <= data_proc_d;
            inflight_q  <= inflight_d;
        end
    end

    // A result with nothing in flight is a processor protocol error and is dropped.
    always_ff @(posedge clk) begin
        if (!rst && vld_pr) begin
            assert (inflight_q != '0);
            assert (!(res_push && fifo_full && !fifo_pop));
        end
    end

    assign fifo_din = {grant_q, res_last, data_from_processor};
    assign fifo_pop = mstr0_data_valid && mstr0_ready;

    bmp_out_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (res_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign mode             = mode_q;
    assign data_proc        = data_proc_q;
    assign mstr0_data_valid = !fifo_empty;
    assign {mstr0_chan, mstr0_cmplt, data_to_master} = fifo_dout;

endmodule

// File: tb/tb_bmp_arbiter_rr.sv
// Scoreboard bench for bmp_arbiter_rr (4 channels, 4-deep FIFO) plus a direct
// push/pop-while-full check of the output FIFO.
module tb_bmp_arbiter_rr;
    import bmp_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int FD = 4;
    localparam int CW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [2*N-1:0]    slv_mode;
    logic [N-1:0]      slv_data_valid;
    logic [N*DW-1:0]   slv_data;
    logic [N-1:0]      slv_last;
    logic [8*N-1:0]    slv_data_proc;
    logic [N-1:0]      slv_ready;
    logic [DW-1:0]     data_to_processor;
    logic              scheduler_2_proc_vld;
    logic              proc_rdy;
    logic [1:0]        mode;
    logic [7:0]        data_proc;
    logic              done;
    logic [DW-1:0]     data_from_processor;
    logic              vld_pr;
    logic              mstr0_ready;
    logic [DW-1:0]     data_to_master;
    logic              mstr0_data_valid;
    logic [CW-1:0]     mstr0_chan;
    logic              mstr0_cmplt;

    bmp_arbiter_rr #(.N_CH(N), .DATA_BUS_SIZE(DW), .FIFO_DEPTH(FD)) u_dut (
        .clk                  (clk),
        .rst                  (rst),
        .slv_mode             (slv_mode),
        .slv_data_valid       (slv_data_valid),
        .slv_data             (slv_data),
        .slv_last             (slv_last),
        .slv_data_proc        (slv_data_proc),
        .slv_ready            (slv_ready),
        .data_to_processor    (data_to_processor),
        .scheduler_2_proc_vld (scheduler_2_proc_vld),
        .proc_rdy             (proc_rdy),
        .mode                 (mode),
        .data_proc            (data_proc),
        .done                 (done),
        .data_from_processor  (data_from_processor),
        .vld_pr               (vld_pr),
        .mstr0_ready          (mstr0_ready),
        .data_to_master       (data_to_master),
        .mstr0_data_valid     (mstr0_data_valid),
        .mstr0_chan           (mstr0_chan),
        .mstr0_cmplt          (mstr0_cmplt)
    );

    logic       f_rst, f_push, f_pop, f_full, f_empty;
    logic [7:0] f_din, f_dout;
    logic [2:0] f_count;

    bmp_out_fifo #(.WIDTH(8), .DEPTH(4)) u_fifo (
        .clk   (clk),
        .rst   (f_rst),
        .push  (f_push),
        .din   (f_din),
        .pop   (f_pop),
        .dout  (f_dout),
        .count (f_count),
        .full  (f_full),
        .empty (f_empty)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // per-channel slave word queues {last, data}, master and done scoreboards
    logic [32:0]      sq [N][$];
    logic [CW+DW:0]   exp_q [$];
    logic [CW+9:0]    done_q [$];
    int               fires [N];
    bit               rr_watch = 0;
    bit               stall_watch = 0;

    function automatic logic [1:0] ready_idx(input logic [N-1:0] r);
        logic [1:0] x;
        x = '0;
        for (int i = 0; i < N; i++) if (r[i]) x = 2'(i);
        return x;
    endfunction

    // slave driver: pop accepted words at negedge, present next word after posedge
    initial begin
        slv_data_valid = '0;
        slv_data       = '0;
        slv_last       = '0;
        for (int i = 0; i < N; i++) fires[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!rst && slv_data_valid[i] && slv_ready[i]) begin
                    fires[i]++;
                    if (sq[i].size() > 0) void'(sq[i].pop_front());
                end
            end
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                if (sq[i].size() > 0) begin
                    slv_data_valid[i]         = 1'b1;
                    slv_data[i*DW +: DW]      = sq[i][0][31:0];
                    slv_last[i]               = sq[i][0][32];
                end else begin
                    slv_data_valid[i]         = 1'b0;
                    slv_data[i*DW +: DW]      = '0;
                    slv_last[i]               = 1'b0;
                end
            end
        end
    end

    // processor model: echo accepted words with two cycles of latency
    initial begin
        logic          s1v, s2v;
        logic [DW-1:0] s1d, s2d;
        s1v = 0; s2v = 0; s1d = '0; s2d = '0;
        vld_pr = 1'b0;
        data_from_processor = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                s1v = 0; s2v = 0;
                vld_pr = 1'b0;
                data_from_processor = '0;
            end else begin
                vld_pr              = s2v;
                data_from_processor = s2d;
                s2v = s1v;
                s2d = s1d;
                s1v = scheduler_2_proc_vld && proc_rdy;
                s1d = data_to_processor;
            end
            #1;
            if (vld_pr)
                chk("no_overflow", 64'(u_dut.fifo_full && !(mstr0_data_valid && mstr0_ready)), 64'd0);
        end
    end

    // monitor: master words, done pulses, and ready watches
    initial begin
        logic [CW+DW:0] e;
        logic [CW+9:0]  d;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mstr0_data_valid && mstr0_ready) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL master_extra: got %0h expected no word", data_to_master);
                    end else begin
                        e = exp_q.pop_front();
                        chk("master_word", 64'({mstr0_chan, mstr0_cmplt, data_to_master}), 64'(e));
                    end
                end
                if (done) begin
                    if (done_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL done_extra: got done expected none");
                    end else begin
                        d = done_q.pop_front();
                        chk("done_grant_mode_dp", 64'({ready_idx(slv_ready), mode, data_proc}), 64'(d));
                    end
                end
                if (rr_watch)    chk("rr_ch0_ready", 64'(slv_ready[0]), 64'd0);
                if (stall_watch) chk("stall_ready_low", 64'(slv_ready), 64'd0);
            end
        end
    end

    task automatic send(input int ch, input int n, input logic [31:0] base, input bit expect_out);
        logic [31:0] w;
        for (int k = 0; k < n; k++) begin
            w = base + 32'(k) * 32'h11;
            sq[ch].push_back({(k == n - 1), w});
            if (expect_out) exp_q.push_back({2'(ch), (k == n - 1), w});
        end
        if (expect_out) done_q.push_back({2'(ch), slv_mode[2*ch +: 2], slv_data_proc[8*ch +: 8]});
    endtask

    task automatic wait_idle(input string nm, input int budget);
        bit ok;
        ok = 0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(posedge clk);
            #1;
            ok = (exp_q.size() == 0) && (done_q.size() == 0) && (u_dut.state_q == ST_IDLE) &&
                 (sq[0].size() == 0) && (sq[1].size() == 0) && (sq[2].size() == 0) && (sq[3].size() == 0);
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL %s: timeout, %0d master words outstanding, expected 0", nm, exp_q.size());
            exp_q.delete();
            done_q.delete();
        end
    endtask

    task automatic wait_fires(input string nm, input int ch, input int target, input int budget);
        bit ok;
        ok = 0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(posedge clk);
            #1;
            ok = (fires[ch] >= target);
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL %s: timeout, accepted %0d expected %0d", nm, fires[ch], target);
        end
    endtask

    initial begin
        int f0;
        int fs;
        rst = 1'b1; proc_rdy = 1'b1; mstr0_ready = 1'b1;
        slv_mode = '0; slv_data_proc = '0;
        f_rst = 1'b1; f_push = 0; f_pop = 0; f_din = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_proc_side", 64'({slv_ready, data_to_processor, scheduler_2_proc_vld, mode, data_proc, done}), 64'd0);
        chk("reset_master_side", 64'({data_to_master, mstr0_data_valid, mstr0_chan, mstr0_cmplt}), 64'd0);
        chk("reset_fifo_count", 64'(u_dut.fifo_count), 64'd0);
        rst = 1'b0; f_rst = 1'b0;

        // single packet on channel 0
        slv_mode[1:0] = 2'd1; slv_data_proc[7:0] = 8'hA5;
        send(0, 3, 32'h11, 1);
        wait_idle("single_packet", 200);

        // round robin between channels 1 and 3: grants 1,3,1,3
        slv_mode[3:2] = 2'd2; slv_data_proc[15:8]  = 8'h21;
        slv_mode[7:6] = 2'd3; slv_data_proc[31:24] = 8'h43;
        rr_watch = 1;
        send(1, 1, 32'h100, 1);
        send(3, 1, 32'h300, 1);
        send(1, 1, 32'h180, 1);
        send(3, 1, 32'h380, 1);
        wait_idle("round_robin", 300);
        rr_watch = 0;

        // backpressure: 10 words into a 4-deep FIFO with master stalled
        slv_mode[5:4] = 2'd2; slv_data_proc[23:16] = 8'h7E;
        mstr0_ready = 1'b0;
        f0 = fires[2];
        send(2, 10, 32'h1000, 1);
        repeat (40) @(posedge clk);
        #1;
        chk("bp_accepted", 64'(fires[2] - f0), 64'd4);
        chk("bp_ready_low", 64'(slv_ready), 64'd0);
        chk("bp_fifo_full", 64'(u_dut.fifo_count), 64'd4);
        mstr0_ready = 1'b1;
        wait_idle("backpressure", 400);

        // processor stall for 5 cycles mid-packet
        f0 = fires[3];
        send(3, 6, 32'h2000, 1);
        wait_fires("stall_start", 3, f0 + 3, 100);
        proc_rdy = 1'b0;
        stall_watch = 1;
        fs = fires[3];
        repeat (5) @(posedge clk);
        #1;
        chk("stall_no_accept", 64'(fires[3] - fs), 64'd0);
        stall_watch = 0;
        proc_rdy = 1'b1;
        wait_idle("proc_stall", 300);

        // reset after 2 of 5 words, then a normal packet from channel 1
        slv_mode[1:0] = 2'd2; slv_data_proc[7:0] = 8'h5A;
        mstr0_ready = 1'b0;
        f0 = fires[0];
        send(0, 5, 32'h3000, 0);
        wait_fires("rst_start", 0, f0 + 2, 100);
        rst = 1'b1;
        sq[0].delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_proc_side", 64'({slv_ready, data_to_processor, scheduler_2_proc_vld, mode, data_proc, done}), 64'd0);
        chk("rst_mid_master_side", 64'({data_to_master, mstr0_data_valid, mstr0_chan, mstr0_cmplt}), 64'd0);
        chk("rst_mid_fifo_count", 64'(u_dut.fifo_count), 64'd0);
        chk("rst_mid_inflight", 64'(u_dut.inflight_q), 64'd0);
        @(posedge clk);
        #1;
        mstr0_ready = 1'b1;
        slv_mode[3:2] = 2'd3; slv_data_proc[15:8] = 8'hC3;
        send(1, 3, 32'h4000, 1);
        wait_idle("after_reset", 200);

        // output FIFO: simultaneous push and pop while full
        begin
            logic [7:0] nexp;
            nexp = 8'd1;
            for (int v = 1; v <= 4; v++) begin
                f_push = 1'b1; f_din = 8'(v);
                @(posedge clk);
                #1;
            end
            f_push = 1'b0;
            chk("ff_full", 64'({f_full, f_count}), 64'({1'b1, 3'd4}));
            for (int v = 5; v <= 7; v++) begin
                f_push = 1'b1; f_pop = 1'b1; f_din = 8'(v);
                chk("ff_head_pushpop", 64'(f_dout), 64'(nexp));
                nexp++;
                @(posedge clk);
                #1;
                chk("ff_count_stays_full", 64'(f_count), 64'd4);
            end
            f_push = 1'b0;
            for (int k = 0; k < 4; k++) begin
                f_pop = 1'b1;
                chk("ff_head_drain", 64'(f_dout), 64'(nexp));
                nexp++;
                @(posedge clk);
                #1;
            end
            f_pop = 1'b0;
            chk("ff_empty", 64'({f_empty, f_count}), 64'({1'b1, 3'd0}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
